// File: rtl/generador_onda_cuad.sv
// Programmable square-wave generator: 1 us tick from the board clock, period and
// high time in us, load/ack configuration applied only at period boundaries.
module generador_onda_cuad #(
    parameter int CICLOS_POR_US = 50,
    parameter int ANCHO         = 12
) (
    input  logic             reloj_placa,
    input  logic             reinicio_n,
    input  logic             habilitar,
    input  logic             cargar,
    input  logic [ANCHO-1:0] periodo_us,
    input  logic [ANCHO-1:0] alto_us,
    output logic             carga_ack,
    output logic             carga_error,
    output logic             onda_cuad,
    output logic             flanco_pos,
    output logic [ANCHO-1:0] ciclos_completos
);

    localparam int PW = (CICLOS_POR_US > 1) ? $clog2(CICLOS_POR_US) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(CICLOS_POR_US - 1);

    typedef enum logic [1:0] {IDLE, ALTO, BAJO} estado_t;

    estado_t          r_estado, w_estado_sig;
    logic [PW-1:0]    r_presc, w_presc_sig;
    logic [ANCHO-1:0] r_cnt_us, w_cnt_us_sig;
    logic [ANCHO-1:0] r_act_per, r_act_alto, w_act_per_sig, w_act_alto_sig;
    logic [ANCHO-1:0] r_pend_per, r_pend_alto, w_pend_per_sig, w_pend_alto_sig;
    logic             r_pend_flag, w_pend_flag_sig;
    logic [ANCHO-1:0] r_ciclos;
    logic             r_onda, r_flanco, r_ack, r_err;

    logic             w_req_valid, w_tick, w_fin_alto, w_frontera;
    logic [ANCHO-1:0] w_alto_m1, w_bajo_m1;

    function automatic logic cfg_ok(input logic [ANCHO-1:0] p, input logic [ANCHO-1:0] a);
        return (p >= ANCHO'(2)) && (a != '0) && (a < p);
    endfunction

    always_comb begin
        w_req_valid = cargar && cfg_ok(periodo_us, alto_us);
        w_tick      = (r_estado != IDLE) && (r_presc == PRESC_MAX);
        w_alto_m1   = r_act_alto - ANCHO'(1);
        w_bajo_m1   = r_act_per - r_act_alto - ANCHO'(1);
        w_fin_alto  = (r_estado == ALTO) && w_tick && (r_cnt_us == w_alto_m1);
        w_frontera  = (r_estado == BAJO) && w_tick && (r_cnt_us == w_bajo_m1);
    end

    // A request arriving on the boundary cycle itself wins over the older pending one.
    always_comb begin
        w_act_per_sig  = r_act_per;
        w_act_alto_sig = r_act_alto;
        if (w_frontera && w_req_valid) begin
            w_act_per_sig  = periodo_us;
            w_act_alto_sig = alto_us;
        end else if ((w_frontera || r_estado == IDLE) && r_pend_flag) begin
            w_act_per_sig  = r_pend_per;
            w_act_alto_sig = r_pend_alto;
        end

        w_pend_per_sig  = r_pend_per;
        w_pend_alto_sig = r_pend_alto;
        if (w_req_valid) begin
            w_pend_per_sig  = periodo_us;
            w_pend_alto_sig = alto_us;
        end

        w_pend_flag_sig = r_pend_flag;
        if (w_frontera) begin
            w_pend_flag_sig = 1'b0;
        end else if (w_req_valid) begin
            w_pend_flag_sig = 1'b1;
        end else if (r_estado == IDLE) begin
            w_pend_flag_sig = 1'b0;
        end
    end

    always_comb begin
        w_estado_sig = r_estado;
        case (r_estado)
            IDLE: if (habilitar && cfg_ok(r_act_per, r_act_alto)) w_estado_sig = ALTO;
            ALTO: if (w_fin_alto) w_estado_sig = BAJO;
            BAJO: if (w_frontera) begin
                w_estado_sig = (habilitar && cfg_ok(w_act_per_sig, w_act_alto_sig)) ? ALTO : IDLE;
            end
            default: w_estado_sig = IDLE;
        endcase

        w_presc_sig = r_presc;
        if (r_estado == IDLE || w_tick) begin
            w_presc_sig = '0;
        end else begin
            w_presc_sig = r_presc + PW'(1);
        end

        w_cnt_us_sig = r_cnt_us;
        if (w_estado_sig != r_estado) begin
            w_cnt_us_sig = '0;
        end else if (w_tick) begin
            w_cnt_us_sig = r_cnt_us + ANCHO'(1);
        end
    end

    always_ff @(posedge reloj_placa or negedge reinicio_n) begin
        if (!reinicio_n) begin
            r_estado    <= IDLE;
            r_presc     <= '0;
            r_cnt_us    <= '0;
            r_act_per   <= '0;
            r_act_alto  <= '0;
            r_pend_per  <= '0;
            r_pend_alto <= '0;
            r_pend_flag <= 1'b0;
            r_ciclos    <= '0;
            r_onda      <= 1'b0;
            r_flanco    <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_estado    <= w_estado_sig;
            r_presc     <= w_presc_sig;
            r_cnt_us    <= w_cnt_us_sig;
            r_act_per   <= w_act_per_sig;
            r_act_alto  <= w_act_alto_sig;
            r_pend_per  <= w_pend_per_sig;
            r_pend_alto <= w_pend_alto_sig;
            r_pend_flag <= w_pend_flag_sig;
            if (w_frontera) r_ciclos <= r_ciclos + ANCHO'(1);
            r_onda      <= (w_estado_sig == ALTO);
            r_flanco    <= (w_estado_sig == ALTO) && (r_estado != ALTO);
            r_ack       <= w_req_valid;
            r_err       <= cargar && !w_req_valid;
        end
    end

    assign onda_cuad        = r_onda;
    assign flanco_pos       = r_flanco;
    assign carga_ack        = r_ack;
    assign carga_error      = r_err;
    assign ciclos_completos = r_ciclos;

endmodule

// File: tb/tb_generador_onda_cuad.sv
// Bench for generador_onda_cuad: clock-count reference model checked every cycle,
// directed waveform measurements, then randomized load/enable/reset traffic.
module tb_generador_onda_cuad;

    localparam int C = 2;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         hab = 1'b0;
    logic         cargar = 1'b0;
    logic [W-1:0] per = '0;
    logic [W-1:0] alto = '0;
    logic         ack, err, onda, flanco;
    logic [W-1:0] ciclos;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // reference model: counts board clocks inside the current period
    int m_on = 0, m_fl = 0, m_ack = 0, m_err = 0, m_cic = 0;
    int m_run = 0, m_cnt = 0, m_ap = 0, m_aa = 0, m_pp = 0, m_pa = 0, m_pf = 0;

    generador_onda_cuad #(.CICLOS_POR_US(C), .ANCHO(W)) dut (
        .reloj_placa      (clk),
        .reinicio_n       (rst_n),
        .habilitar        (hab),
        .cargar           (cargar),
        .periodo_us       (per),
        .alto_us          (alto),
        .carga_ack        (ack),
        .carga_error      (err),
        .onda_cuad        (onda),
        .flanco_pos       (flanco),
        .ciclos_completos (ciclos)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic bit ok_cfg(int p, int a);
        return (p >= 2) && (a >= 1) && (a <= p - 1);
    endfunction

    function automatic void chk(string n, int a, int e);
        total++;
        if (a != e) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", n, a, e, cyc);
        end
    endfunction

    task automatic model_reset();
        m_on = 0; m_fl = 0; m_ack = 0; m_err = 0; m_cic = 0;
        m_run = 0; m_cnt = 0; m_ap = 0; m_aa = 0; m_pp = 0; m_pa = 0; m_pf = 0;
    endtask

    task automatic model_step();
        bit rv;
        bit go;
        rv = cargar && ok_cfg(int'(per), int'(alto));
        m_ack = rv;
        m_err = cargar && !rv;
        m_fl = 0;
        if (!m_run) begin
            go = hab && ok_cfg(m_ap, m_aa);
            if (m_pf) begin m_ap = m_pp; m_aa = m_pa; m_pf = 0; end
            if (go) begin m_run = 1; m_cnt = 0; m_on = 1; m_fl = 1; end
            if (rv) begin m_pp = per; m_pa = alto; m_pf = 1; end
        end else begin
            m_cnt++;
            if (m_cnt == m_aa * C) m_on = 0;
            if (m_cnt == m_ap * C) begin
                m_cic = (m_cic + 1) % (1 << W);
                if (rv) begin m_ap = per; m_aa = alto; end
                else if (m_pf) begin m_ap = m_pp; m_aa = m_pa; end
                m_pf = 0;
                if (hab && ok_cfg(m_ap, m_aa)) begin
                    m_cnt = 0; m_on = 1; m_fl = 1;
                end else begin
                    m_run = 0; m_on = 0;
                end
            end else if (rv) begin
                m_pp = per; m_pa = alto; m_pf = 1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) model_reset();
        else model_step();
    end

    initial forever begin
        @(negedge clk);
        #1;
        chk("onda", onda, m_on);
        chk("flanco", flanco, m_fl);
        chk("ack", ack, m_ack);
        chk("err", err, m_err);
        chk("ciclos", ciclos, m_cic);
    end

    // called right after a negedge; returns right after a later negedge
    task automatic load(input int p, input int a, input int exp_ok);
        cargar = 1'b1;
        per = W'(p);
        alto = W'(a);
        @(negedge clk);
        cargar = 1'b0;
        chk("load_ack", ack, exp_ok);
        chk("load_err", err, 1 - exp_ok);
    endtask

    task automatic wait_rise(input int lim, output int t);
        t = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            if (flanco) begin
                t = cyc;
                return;
            end
        end
        chk("rise_timeout", 0, 1);
    endtask

    task automatic high_len(output int h);
        int t0;
        t0 = cyc;
        h = -1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!onda) begin
                h = cyc - t0;
                return;
            end
        end
        chk("fall_timeout", 0, 1);
    endtask

    task automatic count_rises(input int n, output int k);
        k = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (flanco) k++;
        end
    endtask

    initial begin
        int t1, t2, h, k, c0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_onda", onda, 0);
        chk("rst_ciclos", ciclos, 0);
        chk("rst_ack", ack, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        load(4, 2, 1);
        hab = 1'b1;
        wait_rise(20, t1);
        high_len(h);
        chk("high_4_2", h, 4);
        wait_rise(20, t2);
        chk("period_4_2", t2 - t1, 8);

        load(1, 1, 0);
        load(3, 0, 0);
        load(5, 5, 0);
        wait_rise(20, t1);
        wait_rise(20, t2);
        chk("period_after_bad", t2 - t1, 8);

        load(6, 1, 1);
        wait_rise(20, t1);
        chk("period_keep", t1 - t2, 8);
        high_len(h);
        chk("high_6_1", h, 2);
        wait_rise(30, t2);
        chk("period_6_1", t2 - t1, 12);

        hab = 1'b0;
        c0 = m_cic;
        count_rises(30, k);
        chk("stop_rises", k, 0);
        chk("stop_onda", onda, 0);
        chk("stop_ciclos", ciclos, (c0 + 1) % 16);

        hab = 1'b1;
        wait_rise(10, t1);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_onda", onda, 0);
        chk("rstmid_ciclos", ciclos, 0);
        chk("rstmid_flanco", flanco, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        count_rises(30, k);
        chk("noconf_rises", k, 0);
        chk("noconf_onda", onda, 0);

        load(2, 1, 1);
        wait_rise(10, t1);
        for (int i = 0; i < 17; i++) begin
            wait_rise(10, t2);
            chk("loop_period", t2 - t1, 4);
            t1 = t2;
        end
        chk("wrap_ciclos", ciclos, 1);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cargar = 1'b0;
            if ($urandom_range(0, 7) == 0) begin
                cargar = 1'b1;
                per = W'($urandom_range(0, 15));
                alto = W'($urandom_range(0, 15));
            end
            if ($urandom_range(0, 39) == 0) hab = ~hab;
            if ($urandom_range(0, 799) == 0) rst_n = 1'b0;
            else rst_n = 1'b1;
        end
        @(negedge clk);
        cargar = 1'b0;
        rst_n = 1'b1;
        hab = 1'b0;
        repeat (40) @(negedge clk);
        chk("final_onda", onda, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
